// File: rtl/xor_stream_parity.sv
// xor_stream_parity
//
// XOR-reduces a framed stream of WIDTH-bit words into one WIDTH-bit parity word per frame.
// A frame ends on a beat carrying in_last, or is force-closed when it reaches MAX_LEN beats.
// The result is presented on a valid/ready output together with the frame length and a flag
// telling whether the frame was force-closed. Input is stalled while a result is pending, so at
// most one frame is in flight and the block never accepts a beat in the handoff cycle.
//
// Parameters:
//   WIDTH    data and parity word width in bits (>= 1)
//   MAX_LEN  maximum beats per frame (>= 1)
//   LEN_W    width of out_len, derived from MAX_LEN
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   in_valid      in   input beat valid
//   in_ready      out  block can accept a beat (decoded from state only)
//   in_data       in   input word
//   in_last       in   beat is the last of its frame
//   out_valid     out  frame result valid
//   out_ready     in   downstream accepts the result
//   out_parity    out  XOR of all words in the frame
//   out_len       out  number of beats in the frame (1..MAX_LEN)
//   out_overflow  out  frame was force-closed at MAX_LEN without in_last

module xor_stream_parity #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16,
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_parity,
    output logic [LEN_W-1:0] out_len,
    output logic             out_overflow
);

    typedef enum logic [0:0] {
        StAccum,
        StHold
    } state_e;

    localparam logic [LEN_W-1:0] LastIdx = LEN_W'(MAX_LEN - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] parity_q, parity_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             at_limit;
    logic             closing;
    logic [WIDTH-1:0] acc_next;
    logic [LEN_W-1:0] count_next;

    // in_ready depends on state alone, so there is no path from out_ready to in_ready.
    assign in_ready   = (state_q == StAccum);
    assign accept     = in_valid && in_ready;

    // count_q holds beats already taken, so the beat arriving at LastIdx is beat MAX_LEN.
    assign at_limit   = (count_q == LastIdx);
    assign closing    = in_last || at_limit;
    assign acc_next   = acc_q ^ in_data;
    assign count_next = count_q + LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        parity_d   = parity_q;
        len_d      = len_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;

        case (state_q)
            StAccum: begin
                if (accept) begin
                    if (closing) begin
                        parity_d   = acc_next;
                        len_d      = count_next;
                        // A real in_last on beat MAX_LEN is a normal close, not an overflow.
                        overflow_d = at_limit && !in_last;
                        acc_d      = '0;
                        count_d    = '0;
                        valid_d    = 1'b1;
                        state_d    = StHold;
                    end else begin
                        acc_d   = acc_next;
                        count_d = count_next;
                    end
                end
            end
            StHold: begin
                // Result fields keep their values after handoff; only valid drops.
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StAccum;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StAccum;
            acc_q      <= '0;
            count_q    <= '0;
            parity_q   <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            parity_q   <= parity_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_parity   = parity_q;
    assign out_len      = len_q;
    assign out_overflow = overflow_q;

`ifndef SYNTHESIS
    // A stalled result must not change until it is taken.
    hold_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_parity) && $stable(out_len) && $stable(out_overflow)));

    // Input is only open while no result is pending.
    ready_excl_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));
`endif

endmodule

// File: tb/tb_xor_stream_parity.sv
// tb_xor_stream_parity
//
// Directed bench for xor_stream_parity with WIDTH=8, MAX_LEN=4. A table of per-cycle records
// (inputs plus expected post-edge outputs) covers normal frames, overflow and gapped input;
// reset, back-pressure and reset-during-frame are written out as short sequences.

module tb_xor_stream_parity;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_parity;
    logic [LEN_W-1:0] out_len;
    logic             out_overflow;

    int checks;
    int failures;

    xor_stream_parity #(
        .WIDTH   (WIDTH),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_parity   (out_parity),
        .out_len      (out_len),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             l;
        logic             ordy;
        logic             e_rdy;
        logic             e_vld;
        logic [WIDTH-1:0] e_par;
        logic [LEN_W-1:0] e_len;
        logic             e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [WIDTH-1:0] d, input logic l,
                       input logic ordy, input logic e_rdy, input logic e_vld,
                       input logic [WIDTH-1:0] e_par, input logic [LEN_W-1:0] e_len,
                       input logic e_ovf);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_par = e_par; r.e_len = e_len; r.e_ovf = e_ovf;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l,
                         input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
    endtask

    task automatic check_result(input string name, input logic [WIDTH-1:0] par,
                                input logic [LEN_W-1:0] len, input logic ovf);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".parity"}, 32'(out_parity), 32'(par));
        check({name, ".len"}, 32'(out_len), 32'(len));
        check({name, ".ovf"}, 32'(out_overflow), 32'(ovf));
        check({name, ".in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //    v   data   l  ordy rdy vld par    len ovf
        // Basic frames: 0F^F0^AA = 55, 01^01 = 00. out_ready=1 during ACCUM is ignored.
        add(1, 8'h0F, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'hF0, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'hAA, 1, 1, 0, 1, 8'h55, 3, 0);
        add(1, 8'h77, 1, 1, 1, 0, 8'h00, 0, 0);  // offered in HOLD, handoff cycle
        add(1, 8'h01, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h01, 1, 1, 0, 1, 8'h00, 2, 0);
        add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
        // Overflow: four beats without last force-close, fifth beat is its own frame.
        add(1, 8'h01, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h02, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h04, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h08, 0, 1, 0, 1, 8'h0F, 4, 1);
        add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h10, 1, 1, 0, 1, 8'h10, 1, 0);
        add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
        // in_last exactly on beat MAX_LEN: normal close.
        add(1, 8'h01, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h02, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h04, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h08, 1, 1, 0, 1, 8'h0F, 4, 0);
        add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
        // Gapped input with data and last toggling while invalid: FF^0F = F0.
        add(1, 8'hFF, 0, 1, 1, 0, 8'h00, 0, 0);
        add(0, 8'hA5, 1, 1, 1, 0, 8'h00, 0, 0);
        add(0, 8'h5A, 0, 1, 1, 0, 8'h00, 0, 0);
        add(0, 8'h0F, 1, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h0F, 1, 1, 0, 1, 8'hF0, 2, 0);
        add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);

        // Reset with in_valid high: nothing is taken, outputs at reset values.
        rst_n = 1'b0;
        drive(1, 8'hAB, 1, 1);
        step();
        step();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_parity", 32'(out_parity), 32'h0);
        check("rst.out_len", 32'(out_len), 32'd0);
        check("rst.out_overflow", 32'(out_overflow), 32'd0);
        rst_n = 1'b1;
        drive(0, 8'h00, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ordy);
            step();
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) begin
                check($sformatf("vec%0d.parity", i), 32'(out_parity), 32'(vecs[i].e_par));
                check($sformatf("vec%0d.len", i), 32'(out_len), 32'(vecs[i].e_len));
                check($sformatf("vec%0d.ovf", i), 32'(out_overflow), 32'(vecs[i].e_ovf));
            end
        end

        // Back-pressure: result held for 5 cycles while beats are offered and refused.
        drive(1, 8'h3C, 1, 0);
        step();
        check_result("bp.first", 8'h3C, 1, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 8'h81, 1, 0);
            step();
            check_result($sformatf("bp.hold%0d", k), 8'h3C, 1, 0);
        end
        drive(0, 8'h00, 0, 1);
        step();
        check("bp.release.out_valid", 32'(out_valid), 32'd0);
        check("bp.release.in_ready", 32'(in_ready), 32'd1);
        // A refused 0x81 would have polluted this frame.
        drive(1, 8'h42, 1, 1);
        step();
        check_result("bp.after", 8'h42, 1, 0);
        drive(0, 8'h00, 0, 1);
        step();

        // Reset mid-frame discards the partial 11^22.
        drive(1, 8'h11, 0, 1);
        step();
        drive(1, 8'h22, 0, 1);
        step();
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 1);
        step();
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        drive(1, 8'h44, 1, 1);
        step();
        check_result("midrst.frame", 8'h44, 1, 0);
        drive(0, 8'h00, 0, 1);
        step();

        // Reset while a result is pending drops it.
        drive(1, 8'h99, 1, 0);
        step();
        check_result("holdrst.pending", 8'h99, 1, 0);
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0);
        step();
        check("holdrst.out_valid", 32'(out_valid), 32'd0);
        check("holdrst.in_ready", 32'(in_ready), 32'd1);
        check("holdrst.out_parity", 32'(out_parity), 32'h0);
        rst_n = 1'b1;
        step();
        check("holdrst.idle.out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
